riscv_jal_redirect_ctrl: RTL and testbench

Predecode/redirect stage between the instruction fetch queue and the main decoder. It recognises direct unconditional jumps (JAL, C.J, C.JAL) and computes their target and link values. It requests a fetch redirect and squashes wrong-path instructions using a 1-bit fetch epoch. All other instructions pass through a single registered pipeline stage unchanged.

---
 rtl/riscv_jal_redirect_ctrl.sv | 135 +++++++++++++
 tb/tb_riscv_jal_redirect_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_jal_redirect_ctrl.sv
// Predecode/redirect stage: spots direct jumps (JAL, C.J, C.JAL), computes target/link,
// requests a fetch redirect and drops wrong-path entries using a 1-bit fetch epoch.
module riscv_jal_redirect_ctrl #(
    parameter bit RVC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        in_epoch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_jump,
    output logic [31:0] out_target,
    output logic [31:0] out_link,
    output logic        out_exc,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc
);

    typedef enum logic [0:0] {RUN, REDIR} state_t;

    typedef struct packed {
        logic        is_jump;
        logic [31:0] target;
        logic [31:0] link;
        logic        exc;
    } dec_t;

    state_t      state, state_nxt;
    logic        cur_epoch;
    logic        is_jal, is_cjmp;
    logic [31:0] imm_j, imm_c;
    dec_t        dec;
    logic        load, redir_fire, take_redir;

    assign is_jal  = (in_instr[6:0] == 7'b1101111);
    assign is_cjmp = RVC_EN && (in_instr[1:0] == 2'b01) &&
                     ((in_instr[15:13] == 3'b101) || (in_instr[15:13] == 3'b001));

    assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_c = {{21{in_instr[12]}}, in_instr[8], in_instr[10:9], in_instr[6], in_instr[7],
                    in_instr[2], in_instr[11], in_instr[5:3], 1'b0};

    always_comb begin
        dec = '0;
        if (is_jal) begin
            dec.is_jump = 1'b1;
            dec.target  = in_pc + imm_j;
            dec.link    = in_pc + 32'd4;
        end else if (is_cjmp) begin
            dec.is_jump = 1'b1;
            dec.target  = in_pc + imm_c;
            dec.link    = in_pc + 32'd2;
        end
        // Without RVC a halfword-aligned target is unreachable: flag it instead of redirecting.
        dec.exc = dec.is_jump && !RVC_EN && dec.target[1];
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        redir_fire = 1'b0;
        take_redir = 1'b0;
        if (flush) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    in_ready   = !out_valid || out_ready;
                    load       = in_valid && in_ready && (in_epoch == cur_epoch);
                    take_redir = load && dec.is_jump && !dec.exc;
                    if (take_redir) state_nxt = REDIR;
                end
                REDIR: begin
                    in_ready   = 1'b1;
                    redir_fire = redir_valid && redir_ready;
                    if (redir_fire) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_epoch   <= 1'b0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_is_jump <= 1'b0;
            out_target  <= '0;
            out_link    <= '0;
            out_exc     <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else if (flush) begin
            cur_epoch   <= ~cur_epoch;
            out_valid   <= 1'b0;
            redir_valid <= 1'b0;
        end else begin
            if (redir_fire) begin
                cur_epoch   <= ~cur_epoch;
                redir_valid <= 1'b0;
            end else if (take_redir) begin
                redir_valid <= 1'b1;
                redir_pc    <= dec.target;
            end
            if (load) begin
                out_valid   <= 1'b1;
                out_instr   <= in_instr;
                out_pc      <= in_pc;
                out_is_jump <= dec.is_jump;
                out_target  <= dec.target;
                out_link    <= dec.link;
                out_exc     <= dec.exc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_jal_redirect_ctrl.sv
// Directed bench: table of single-entry decode vectors on RVC_EN=1/0 instances, plus
// hand sequences for redirect stall, backpressure, flush-vs-redirect and reset.
module tb_riscv_jal_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_epoch, out_ready, redir_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready1, out_valid1, out_is_jump1, out_exc1, redir_valid1;
    logic [31:0] out_instr1, out_pc1, out_target1, out_link1, redir_pc1;
    logic        in_ready0, out_valid0, out_is_jump0, out_exc0, redir_valid0;
    logic [31:0] out_instr0, out_pc0, out_target0, out_link0, redir_pc0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_jal_redirect_ctrl #(.RVC_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr), .in_pc(in_pc),
        .in_epoch(in_epoch), .out_valid(out_valid1), .out_ready(out_ready),
        .out_instr(out_instr1), .out_pc(out_pc1), .out_is_jump(out_is_jump1),
        .out_target(out_target1), .out_link(out_link1), .out_exc(out_exc1),
        .redir_valid(redir_valid1), .redir_ready(redir_ready), .redir_pc(redir_pc1)
    );

    riscv_jal_redirect_ctrl #(.RVC_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_instr(in_instr), .in_pc(in_pc),
        .in_epoch(in_epoch), .out_valid(out_valid0), .out_ready(out_ready),
        .out_instr(out_instr0), .out_pc(out_pc0), .out_is_jump(out_is_jump0),
        .out_target(out_target0), .out_link(out_link0), .out_exc(out_exc0),
        .redir_valid(redir_valid0), .redir_ready(redir_ready), .redir_pc(redir_pc0)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        j1;
        logic [31:0] t1;
        logic [31:0] l1;
        logic        rd1;
        logic        j0;
        logic [31:0] t0;
        logic [31:0] l0;
        logic        e0;
        logic        rd0;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        in_epoch    = 1'b0;
        out_ready   = 1'b0;
        redir_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc, input logic ep);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        in_epoch = ep;
    endtask

    initial begin
        //           instr         pc            j1 t1            l1            rd1 j0 t0            l0            e0 rd0
        vecs[0] = '{32'h008000EF, 32'h00000100, 1, 32'h00000108, 32'h00000104, 1, 1, 32'h00000108, 32'h00000104, 0, 1};
        vecs[1] = '{32'hFFDFF0EF, 32'h00001000, 1, 32'h00000FFC, 32'h00001004, 1, 1, 32'h00000FFC, 32'h00001004, 0, 1};
        vecs[2] = '{32'hFFDFF0EF, 32'h00000000, 1, 32'hFFFFFFFC, 32'h00000004, 1, 1, 32'hFFFFFFFC, 32'h00000004, 0, 1};
        vecs[3] = '{32'h0000A011, 32'h00000200, 1, 32'h00000204, 32'h00000202, 1, 0, 32'h0,         32'h0,         0, 0};
        vecs[4] = '{32'h00003FFD, 32'h00000300, 1, 32'h000002FE, 32'h00000302, 1, 0, 32'h0,         32'h0,         0, 0};
        vecs[5] = '{32'h002000EF, 32'h00000100, 1, 32'h00000102, 32'h00000104, 1, 1, 32'h00000102, 32'h00000104, 1, 0};
        vecs[6] = '{32'h00000013, 32'h00000400, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         0, 0};
        vecs[7] = '{32'h00000001, 32'h00000500, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         0, 0};

        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst out_valid", {31'b0, out_valid1}, 32'd0);
        chk("rst redir_valid", {31'b0, redir_valid1}, 32'd0);
        chk("rst out_target", out_target1, 32'd0);
        chk("rst redir_pc", redir_pc1, 32'd0);
        chk("rst in_ready", {31'b0, in_ready1}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            present(vecs[i].instr, vecs[i].pc, 1'b0);
            tick();
            idle_inputs();
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid1}, 32'd1);
            chk($sformatf("v%0d out_pc", i), out_pc1, vecs[i].pc);
            chk($sformatf("v%0d out_instr", i), out_instr1, vecs[i].instr);
            chk($sformatf("v%0d is_jump", i), {31'b0, out_is_jump1}, {31'b0, vecs[i].j1});
            chk($sformatf("v%0d target", i), out_target1, vecs[i].t1);
            chk($sformatf("v%0d link", i), out_link1, vecs[i].l1);
            chk($sformatf("v%0d exc", i), {31'b0, out_exc1}, 32'd0);
            chk($sformatf("v%0d redir_valid", i), {31'b0, redir_valid1}, {31'b0, vecs[i].rd1});
            if (vecs[i].rd1) chk($sformatf("v%0d redir_pc", i), redir_pc1, vecs[i].t1);
            chk($sformatf("v%0d rvc0 is_jump", i), {31'b0, out_is_jump0}, {31'b0, vecs[i].j0});
            chk($sformatf("v%0d rvc0 target", i), out_target0, vecs[i].t0);
            chk($sformatf("v%0d rvc0 link", i), out_link0, vecs[i].l0);
            chk($sformatf("v%0d rvc0 exc", i), {31'b0, out_exc0}, {31'b0, vecs[i].e0});
            chk($sformatf("v%0d rvc0 redir_valid", i), {31'b0, redir_valid0}, {31'b0, vecs[i].rd0});
        end

        // Redirect stall: five wrong-path inputs while fetch withholds redir_ready.
        do_reset();
        present(32'h008000EF, 32'h100, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            present(32'h00000013, 32'h104 + 32'(4 * k), 1'b0);
            #1;
            chk($sformatf("stall%0d in_ready", k), {31'b0, in_ready1}, 32'd1);
            tick();
            chk($sformatf("stall%0d out_valid", k), {31'b0, out_valid1}, 32'd0);
            chk($sformatf("stall%0d redir_valid", k), {31'b0, redir_valid1}, 32'd1);
            chk($sformatf("stall%0d redir_pc", k), redir_pc1, 32'h108);
        end
        redir_ready = 1'b1;
        present(32'h00000013, 32'h108, 1'b1);
        tick();
        redir_ready = 1'b0;
        chk("hs cycle dropped", {31'b0, out_valid1}, 32'd0);
        chk("hs redir_valid", {31'b0, redir_valid1}, 32'd0);
        present(32'h00000013, 32'h120, 1'b0);
        tick();
        chk("old epoch dropped", {31'b0, out_valid1}, 32'd0);
        present(32'h00000013, 32'h108, 1'b1);
        tick();
        chk("new epoch out_valid", {31'b0, out_valid1}, 32'd1);
        chk("new epoch out_pc", out_pc1, 32'h108);

        // Backpressure: held output blocks input in RUN, then streams 1/cycle.
        out_ready = 1'b0;
        present(32'h00000013, 32'h10C, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d in_ready", k), {31'b0, in_ready1}, 32'd0);
            tick();
            chk($sformatf("bp%0d out_valid", k), {31'b0, out_valid1}, 32'd1);
            chk($sformatf("bp%0d out_pc", k), out_pc1, 32'h108);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            present(32'h00000013, 32'h10C + 32'(4 * k), 1'b1);
            #1;
            chk($sformatf("tp%0d in_ready", k), {31'b0, in_ready1}, 32'd1);
            tick();
            chk($sformatf("tp%0d out_pc", k), out_pc1, 32'h10C + 32'(4 * k));
        end

        // Flush coinciding with a redirect handshake toggles the epoch only once (1 -> 0).
        present(32'h008000EF, 32'h200, 1'b1);
        tick();
        chk("fl redir_valid", {31'b0, redir_valid1}, 32'd1);
        flush = 1'b1;
        redir_ready = 1'b1;
        present(32'h00000013, 32'h208, 1'b1);
        #1;
        chk("fl in_ready", {31'b0, in_ready1}, 32'd0);
        tick();
        flush = 1'b0;
        redir_ready = 1'b0;
        chk("fl out_valid", {31'b0, out_valid1}, 32'd0);
        chk("fl redir_valid clr", {31'b0, redir_valid1}, 32'd0);
        present(32'h00000013, 32'h300, 1'b1);
        tick();
        chk("fl epoch1 dropped", {31'b0, out_valid1}, 32'd0);
        present(32'h00000013, 32'h304, 1'b0);
        tick();
        chk("fl epoch0 fwd", {31'b0, out_valid1}, 32'd1);
        chk("fl epoch0 pc", out_pc1, 32'h304);

        // Reset in the middle of a redirect.
        present(32'h008000EF, 32'h400, 1'b0);
        tick();
        chk("mr redir_valid", {31'b0, redir_valid1}, 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("mr out_valid", {31'b0, out_valid1}, 32'd0);
        chk("mr redir_valid", {31'b0, redir_valid1}, 32'd0);
        chk("mr redir_pc", redir_pc1, 32'd0);
        chk("mr out_target", out_target1, 32'd0);
        chk("mr out_link", out_link1, 32'd0);
        chk("mr out_pc", out_pc1, 32'd0);
        present(32'h00000013, 32'h600, 1'b0);
        tick();
        chk("mr epoch0 fwd", {31'b0, out_valid1}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
